// File: rtl/lcd_timing.sv
// lcd_timing: raster timing generator and two-stage pixel output stage for a
// parallel RGB565 LCD. Stage 1 turns the h/v counters into pixel coordinates
// and sync/enable flags. Stage 2 captures the pattern colour and re-times the
// flags so that the colour, DE, HSYNC and VSYNC leave together.
module lcd_timing #(
    parameter int H_ACTIVE = 480,
    parameter int H_FP     = 8,
    parameter int H_SYNC   = 4,
    parameter int H_BP     = 43,
    parameter int V_ACTIVE = 272,
    parameter int V_FP     = 8,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 12,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    output logic [8:0] o_x,
    output logic [8:0] o_y,
    input  logic [4:0] i_R,
    input  logic [5:0] i_G,
    input  logic [4:0] i_B,
    output logic [4:0] o_R,
    output logic [5:0] o_G,
    output logic [4:0] o_B,
    output logic       o_de,
    output logic       o_hs,
    output logic       o_vs,
    output logic       o_frame
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0] H_ACT_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [8:0] V_LAST     = 9'(V_TOTAL - 1);
    localparam logic [8:0] V_ACT      = 9'(V_ACTIVE);
    localparam logic [8:0] V_ACT_LAST = 9'(V_ACTIVE - 1);
    localparam logic [8:0] VS_START   = 9'(V_ACTIVE + V_FP);
    localparam logic [8:0] VS_END     = 9'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] h_cnt;
    logic [8:0] v_cnt;

    logic h_wrap;
    logic v_wrap;
    logic active;
    logic hs_on;
    logic vs_on;
    logic frame_hit;

    logic de1;
    logic hs1;
    logic vs1;

    // Decode the raster position into wrap points, active area and sync windows
    always_comb begin
        h_wrap    = (h_cnt == H_LAST);
        v_wrap    = (v_cnt == V_LAST);
        active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs_on     = (h_cnt >= HS_START) && (h_cnt < HS_END);
        vs_on     = (v_cnt >= VS_START) && (v_cnt < VS_END);
        frame_hit = (h_cnt == H_ACT_LAST) && (v_cnt == V_ACT_LAST);
    end

    // Horizontal counter runs every clock; vertical advances only at line wrap
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            v_cnt <= v_wrap ? '0 : v_cnt + 9'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    // Stage 1: coordinates for the pattern logic, flags, and end-of-frame strobe
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_x     <= '0;
            o_y     <= '0;
            de1     <= 1'b0;
            hs1     <= ~HS_POL;
            vs1     <= ~VS_POL;
            o_frame <= 1'b0;
        end else begin
            o_x     <= active ? h_cnt[8:0] : 9'd0;
            o_y     <= active ? v_cnt : 9'd0;
            de1     <= active;
            hs1     <= hs_on ? HS_POL : ~HS_POL;
            vs1     <= vs_on ? VS_POL : ~VS_POL;
            o_frame <= frame_hit;
        end
    end

    // Stage 2: capture the pattern colour and delay the flags to stay aligned with it
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_R  <= '0;
            o_G  <= '0;
            o_B  <= '0;
            o_de <= 1'b0;
            o_hs <= ~HS_POL;
            o_vs <= ~VS_POL;
        end else begin
            o_R  <= de1 ? i_R : 5'd0;
            o_G  <= de1 ? i_G : 6'd0;
            o_B  <= de1 ? i_B : 5'd0;
            o_de <= de1;
            o_hs <= hs1;
            o_vs <= vs1;
        end
    end

endmodule
